distance_smoother: RTL

//  Conditions raw distance samples before they drive the distance-to-frequency-step LUT
//  of the FM NCO stage; it sits directly upstream of that stage.
//  Per accepted sample: clamp to MAX_DIST, then apply a 2**AVG_LOG2-point moving average,

---
 rtl/fm_pkg.sv | 11 +
 rtl/dist_ring_buffer.sv | 36 +++
 rtl/distance_smoother.sv | 115 +++++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// Shared FM distance-path constants and types, also used by the NCO stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fm_pkg;

  localparam int DIST_WIDTH = 13;
  localparam int MAX_DIST   = 2000;

  typedef logic [DIST_WIDTH-1:0] dist_t;

endpackage

// File: rtl/dist_ring_buffer.sv
// Moving-average history: 2**AVG_LOG2 entries, one write port, read at the write pointer.
// Latency: read is combinational (returns the entry about to be overwritten).
// Backpressure: none; a write happens on every cycle wr_en is high.
module dist_ring_buffer
  import fm_pkg::*;
#(
  parameter int WIDTH    = DIST_WIDTH,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << AVG_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;

  // Oldest sample sits at the write pointer once the ring has wrapped.
  assign rd_data = mem[wr_ptr];

  // Write pointer advances per write and wraps naturally at the array depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
  end

  // Storage is deliberately not reset; reads are masked until the window is primed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/distance_smoother.sv
// Clamp -> 2**AVG_LOG2-point moving average -> per-update slew limit, feeding the NCO LUT.
// Latency: out_valid rises 2 clock edges after the edge that accepts the sample.
// Backpressure: none; enable=0 freezes every stage and drops incoming samples.
module distance_smoother
  import fm_pkg::*;
#(
  parameter int WIDTH     = DIST_WIDTH,
  parameter int AVG_LOG2  = 4,
  parameter int MAX_DIST  = fm_pkg::MAX_DIST,
  parameter int SLEW_STEP = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_distance,
  output logic [WIDTH-1:0] out_distance,
  output logic             out_valid,
  output logic             filled
);

  localparam int SW    = WIDTH + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(DEPTH);
  localparam logic [WIDTH-1:0]  CEIL = WIDTH'(MAX_DIST);
  localparam logic [WIDTH-1:0]  STEP = WIDTH'(SLEW_STEP);

  logic             accept;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] old_raw;
  logic [WIDTH-1:0] old;

  logic [SW-1:0]     sum;
  logic [AVG_LOG2:0] fill_cnt;
  logic              v0;
  logic              v1;
  logic [WIDTH-1:0]  mean;
  logic              primed;
  logic              out_valid_q;
  logic [WIDTH-1:0]  next_out;

  assign accept  = in_valid & enable;
  assign clamped = (in_distance > CEIL) ? CEIL : in_distance;
  // Unwritten ring entries hold garbage, so nothing is subtracted until primed.
  assign old     = filled ? old_raw : '0;

  dist_ring_buffer #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ring (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (accept),
    .wr_data (clamped),
    .rd_data (old_raw)
  );

  // Stage 0: running sum update and window-fill tracking on each accepted sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum      <= '0;
      fill_cnt <= '0;
      filled   <= 1'b0;
      v0       <= 1'b0;
    end else if (enable) begin
      v0 <= in_valid;
      if (in_valid) begin
        sum <= sum + SW'(clamped) - SW'(old);
        if (fill_cnt != FULL) fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == FULL - 1'b1) filled <= 1'b1;
      end
    end
  end

  // Stage 1: mean of the window, only once the window holds a full set of samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      mean <= '0;
    end else if (enable) begin
      v1 <= v0 & filled;
      if (v0 & filled) mean <= WIDTH'(sum >> AVG_LOG2);
    end
  end

  // Slew decision, compared one bit wider so out_distance - STEP never wraps.
  always_comb begin
    next_out = mean;
    if (primed) begin
      if ({1'b0, mean} > ({1'b0, out_distance} + {1'b0, STEP}))
        next_out = out_distance + STEP;
      else if (({1'b0, mean} + {1'b0, STEP}) < {1'b0, out_distance})
        next_out = out_distance - STEP;
    end
  end

  // Stage 2: registered output; the first update after priming jumps straight to the mean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_distance <= '0;
      out_valid_q  <= 1'b0;
      primed       <= 1'b0;
    end else if (enable) begin
      out_valid_q <= v1;
      if (v1) begin
        out_distance <= next_out;
        primed       <= 1'b1;
      end
    end
  end

  // A strobe caught by a freeze stays pending and is shown once enable returns.
  assign out_valid = out_valid_q & enable;

endmodule
